irq_ctrl: RTL and testbench



---
 rtl/irq_ctrl_if.sv | 11 +
 rtl/irq_ctrl.sv | 102 ++++++++++
 tb/tb_irq_ctrl.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/irq_ctrl_if.sv
// Bridge-side register bus for the interrupt controller: word address,
// write strobe, write data and combinational read data.
interface irq_ctrl_if;
   logic [29:0] Addr;
   logic        WE;
   logic [31:0] Din;
   logic [31:0] Dout;

   modport master (output Addr, output WE, output Din, input Dout);
   modport slave  (input Addr, input WE, input Din, output Dout);
endinterface

// File: rtl/irq_ctrl.sv
// Memory-mapped interrupt controller: latches edge/level requests, masks them,
// gates with a global enable and reports the lowest-index pending source.
module irq_ctrl #(
   parameter int N   = 6,
   parameter int IDW = 3
) (
   input  logic           clk,
   input  logic           reset,
   irq_ctrl_if.slave      bus,
   input  logic [N-1:0]   irq_in,
   output logic [N-1:0]   hw_int,
   output logic           IRQ
);

   localparam logic [2:0] A_PEND = 3'd0, A_MASK = 3'd1, A_MODE = 3'd2,
                          A_CTRL = 3'd3, A_CLAIM = 3'd4;

   logic [N-1:0]   pending_q, pending_d;
   logic [N-1:0]   mask_q, mask_d;
   logic [N-1:0]   mode_q, mode_d;
   logic           gie_q, gie_d;
   logic [N-1:0]   irq_q, irq_d;

   logic [2:0]     addr;
   logic [N-1:0]   rise, clr, pm;
   logic           valid;
   logic [IDW-1:0] id;
   logic           unused_bits;

   assign addr        = bus.Addr[2:0];
   assign unused_bits = ^{bus.Addr[29:3], bus.Din};

   always_comb begin
      clr       = '0;
      mask_d    = mask_q;
      mode_d    = mode_q;
      gie_d     = gie_q;
      irq_d     = irq_in;
      rise      = irq_in & ~irq_q;

      if (bus.WE) begin
         case (addr)
            A_PEND: clr = bus.Din[N-1:0];
            A_MASK: mask_d = bus.Din[N-1:0];
            A_MODE: mode_d = bus.Din[N-1:0];
            A_CTRL: gie_d = bus.Din[0];
            A_CLAIM: begin
               // ids >= N match no bit and are dropped here
               for (int i = 0; i < N; i++)
                  if (bus.Din[IDW-1:0] == i[IDW-1:0]) clr[i] = 1'b1;
            end
            default: ;
         endcase
      end

      // edge bits: a fresh rising edge beats a same-cycle clear; level bits track the line
      pending_d = (mode_q & ((pending_q & ~clr) | rise)) | (~mode_q & irq_in);
   end

   always_comb begin
      pm    = pending_q & mask_q;
      valid = |pm;
      id    = '0;
      for (int i = N - 1; i >= 0; i--)
         if (pm[i]) id = i[IDW-1:0];
   end

   always_comb begin
      bus.Dout = '0;
      case (addr)
         A_PEND:  bus.Dout[N-1:0] = pending_q;
         A_MASK:  bus.Dout[N-1:0] = mask_q;
         A_MODE:  bus.Dout[N-1:0] = mode_q;
         A_CTRL:  bus.Dout[0]     = gie_q;
         A_CLAIM: begin
            bus.Dout[31]      = valid;
            bus.Dout[IDW-1:0] = id;
         end
         default: ;
      endcase
   end

   assign hw_int = pending_q & mask_q & {N{gie_q}};
   assign IRQ    = |hw_int;

   always_ff @(posedge clk) begin
      if (reset) begin
         pending_q <= '0;
         mask_q    <= '0;
         mode_q    <= '0;
         gie_q     <= 1'b0;
         irq_q     <= '0;
      end else begin
         pending_q <= pending_d;
         mask_q    <= mask_d;
         mode_q    <= mode_d;
         gie_q     <= gie_d;
         irq_q     <= irq_d;
      end
   end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed and randomized checks of irq_ctrl against a per-source
// behavioural model of the register map and latching rules.
module tb_irq_ctrl;
   localparam int N = 6;
   localparam int IDW = 3;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic [N-1:0] irq_in = '0;
   logic [N-1:0] hw_int;
   logic         IRQ;

   irq_ctrl_if bus ();

   irq_ctrl #(.N(N), .IDW(IDW)) dut (
      .clk(clk), .reset(reset), .bus(bus),
      .irq_in(irq_in), .hw_int(hw_int), .IRQ(IRQ)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_pass = 0;

   // reference state: one entry per source
   bit m_pend [N];
   bit m_mask [N];
   bit m_edge [N];
   bit m_last [N];
   bit m_gie;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   function automatic logic [31:0] m_read(input int a);
      logic [31:0] r;
      r = '0;
      case (a)
         0: for (int i = 0; i < N; i++) r[i] = m_pend[i];
         1: for (int i = 0; i < N; i++) r[i] = m_mask[i];
         2: for (int i = 0; i < N; i++) r[i] = m_edge[i];
         3: r[0] = m_gie;
         4: begin
            for (int i = N - 1; i >= 0; i--)
               if (m_pend[i] && m_mask[i]) r = 32'h8000_0000 | i;
         end
         default: r = '0;
      endcase
      return r;
   endfunction

   function automatic logic [N-1:0] m_hw();
      logic [N-1:0] h;
      for (int i = 0; i < N; i++) h[i] = m_pend[i] & m_mask[i] & m_gie;
      return h;
   endfunction

   // Advance model and DUT by one edge, then compare the interrupt outputs.
   task automatic step();
      bit np [N]; bit nm [N]; bit ne [N]; bit ng;
      int a;
      bit clr;
      a = int'(bus.Addr[2:0]);
      ng = m_gie;
      for (int i = 0; i < N; i++) begin
         nm[i] = m_mask[i];
         ne[i] = m_edge[i];
         if (m_edge[i]) begin
            clr = bus.WE && ((a == 0 && bus.Din[i]) || (a == 4 && int'(bus.Din[IDW-1:0]) == i));
            if (irq_in[i] && !m_last[i]) np[i] = 1'b1;
            else if (clr)                np[i] = 1'b0;
            else                         np[i] = m_pend[i];
         end else begin
            np[i] = irq_in[i];
         end
         if (bus.WE && a == 1) nm[i] = bus.Din[i];
         if (bus.WE && a == 2) ne[i] = bus.Din[i];
      end
      if (bus.WE && a == 3) ng = bus.Din[0];
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
         m_pend[i] = reset ? 1'b0 : np[i];
         m_mask[i] = reset ? 1'b0 : nm[i];
         m_edge[i] = reset ? 1'b0 : ne[i];
         m_last[i] = reset ? 1'b0 : irq_in[i];
      end
      m_gie = reset ? 1'b0 : ng;
      chk("hw_int", 32'(hw_int), 32'(m_hw()));
      chk("IRQ", 32'(IRQ), 32'(|m_hw()));
   endtask

   task automatic wr(input int a, input logic [31:0] d);
      bus.Addr = 30'(a);
      bus.WE   = 1'b1;
      bus.Din  = d;
      step();
      bus.WE   = 1'b0;
      bus.Din  = '0;
   endtask

   task automatic rd(input string tag, input int a);
      bus.Addr = 30'(a);
      bus.WE   = 1'b0;
      #1;
      chk(tag, bus.Dout, m_read(a));
   endtask

   task automatic rdx(input string tag, input int a, input logic [31:0] exp);
      bus.Addr = 30'(a);
      bus.WE   = 1'b0;
      #1;
      chk(tag, bus.Dout, exp);
      chk({tag, "_model"}, bus.Dout, m_read(a));
   endtask

   initial begin
      bus.Addr = '0; bus.WE = 1'b0; bus.Din = '0;
      for (int i = 0; i < N; i++) begin
         m_pend[i] = 0; m_mask[i] = 0; m_edge[i] = 0; m_last[i] = 0;
      end
      m_gie = 0;

      // reset state
      reset = 1'b1; step(); step(); reset = 1'b0;
      for (int a = 0; a < 5; a++) rdx($sformatf("rst_rd%0d", a), a, 32'h0);
      chk("rst_irq", 32'(IRQ), 32'h0);

      // single edge source, claim and ack
      wr(2, 32'h2); wr(1, 32'h2); wr(3, 32'h1);
      irq_in = 6'h02; step(); irq_in = '0;
      chk("edge_irq", 32'(IRQ), 32'h1);
      rdx("edge_pend", 0, 32'h2);
      rdx("edge_claim", 4, 32'h8000_0001);
      wr(4, 32'h1);
      rdx("ack_pend", 0, 32'h0);
      chk("ack_irq", 32'(IRQ), 32'h0);

      // level source ignores W1C
      wr(2, 32'h0); wr(1, 32'h3F);
      irq_in = 6'h10; step();
      chk("lvl_irq", 32'(IRQ), 32'h1);
      wr(0, 32'h10);
      rdx("lvl_w1c", 0, 32'h10);
      irq_in = '0; step();
      rdx("lvl_drop", 0, 32'h0);
      chk("lvl_irq0", 32'(IRQ), 32'h0);

      // priority among two edge sources
      wr(2, 32'h9);
      irq_in = 6'h09; step(); irq_in = '0; step();
      rdx("pri_c0", 4, 32'h8000_0000);
      wr(4, 32'h0);
      rdx("pri_c3", 4, 32'h8000_0003);
      wr(4, 32'h3);
      rdx("pri_none", 4, 32'h0);
      wr(4, 32'h7);   // out-of-range id is ignored
      rdx("pri_oor", 0, 32'h0);

      // W1C concurrent with a new rising edge: set wins
      wr(2, 32'h4);
      irq_in = 6'h04;
      wr(0, 32'h4);
      irq_in = '0;
      rdx("setwins", 0, 32'h4);
      wr(0, 32'h4);
      rdx("setwins_clr", 0, 32'h0);

      // masked latching, GIE gating, reset
      wr(1, 32'h0); wr(2, 32'h1);
      irq_in = 6'h01; step(); irq_in = '0;
      chk("msk_irq", 32'(IRQ), 32'h0);
      rdx("msk_pend", 0, 32'h1);
      wr(3, 32'h0); wr(1, 32'h1);
      chk("gie0_irq", 32'(IRQ), 32'h0);
      wr(3, 32'h1);
      chk("gie1_irq", 32'(IRQ), 32'h1);
      reset = 1'b1; step(); reset = 1'b0;
      for (int a = 0; a < 5; a++) rdx($sformatf("rst2_rd%0d", a), a, 32'h0);
      chk("rst2_irq", 32'(IRQ), 32'h0);

      // randomized traffic
      for (int k = 0; k < 600; k++) begin
         irq_in   = N'($urandom);
         reset    = ($urandom_range(0, 99) == 0);
         bus.WE   = ($urandom_range(0, 3) == 0);
         bus.Addr = 30'($urandom_range(0, 7));
         bus.Din  = $urandom;
         if (bus.Addr[2:0] == 3'd4) bus.Din[IDW-1:0] = 3'($urandom_range(0, 7));
         step();
         reset  = 1'b0;
         bus.WE = 1'b0;
         rd("rnd_rd", $urandom_range(0, 7));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
